// File: rtl/my_processor_nios2_qsys_oci_dct_packer.sv
// Trace symbol packer: gathers 3-bit symbols into 30-bit words and
// hands them downstream, with idle-timeout flush and drain-to-stop control.
module my_processor_nios2_qsys_oci_dct_packer #(
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        tr_valid,
    input  logic [2:0]  tr_sym,
    output logic        tr_ready,
    output logic [29:0] dct_buffer,
    output logic [3:0]  dct_count,
    output logic        dct_valid,
    input  logic        dct_ready,
    input  logic        test_ending,
    output logic        test_has_ended,
    output logic        sym_dropped
);

    typedef enum logic [1:0] {
        RUN,
        DRAIN,
        DONE
    } state_t;

    localparam logic [7:0] TMO = 8'(TIMEOUT_CYCLES);

    state_t      state_q, state_d;
    logic [29:0] acc_q, acc_d;
    logic [3:0]  fill_q, fill_d;
    logic [7:0]  idle_q, idle_d;
    logic [5:0]  shamt;
    logic        out_free;
    logic        timeout_hit;
    logic        flush_due;
    logic        move;
    logic        accept;

    always_comb begin
        out_free    = !dct_valid || dct_ready;
        timeout_hit = (TMO != 8'd0) && (idle_q >= TMO);
        flush_due   = (fill_q != 4'd0) && (timeout_hit || state_q == DRAIN);
        move        = out_free && (fill_q == 4'd10 || flush_due);
        tr_ready    = reset_n && (state_q == RUN)
                      && (fill_q < 4'd10 || out_free);
        accept      = tr_valid && tr_ready;

        // A move empties the accumulator first, so a same-cycle symbol lands at index 0
        acc_d  = move ? '0 : acc_q;
        fill_d = move ? 4'd0 : fill_q;
        shamt  = {2'b00, fill_d} + {1'b0, fill_d, 1'b0};
        if (accept) begin
            acc_d  = acc_d | ({27'b0, tr_sym} << shamt);
            fill_d = fill_d + 4'd1;
        end

        idle_d = idle_q;
        if (accept || move || fill_q == 4'd0) begin
            idle_d = 8'd0;
        end else if (fill_q != 4'd10 && idle_q != 8'hff) begin
            idle_d = idle_q + 8'd1;
        end

        state_d = state_q;
        unique case (state_q)
            RUN:     if (test_ending) state_d = DRAIN;
            DRAIN:   if (fill_q == 4'd0 && out_free) state_d = DONE;
            DONE:    state_d = DONE;
            default: state_d = RUN;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= RUN;
            acc_q       <= '0;
            fill_q      <= '0;
            idle_q      <= '0;
            dct_buffer  <= '0;
            dct_count   <= '0;
            dct_valid   <= 1'b0;
            sym_dropped <= 1'b0;
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
            fill_q  <= fill_d;
            idle_q  <= idle_d;
            if (move) begin
                dct_buffer <= acc_q;
                dct_count  <= fill_q;
                dct_valid  <= 1'b1;
            end else if (dct_valid && dct_ready) begin
                dct_valid <= 1'b0;
            end
            if (tr_valid && state_q != RUN) begin
                sym_dropped <= 1'b1;
            end
        end
    end

    assign test_has_ended = (state_q == DONE);

endmodule
